// File: rtl/axi_req_bridge.sv
// axi_req_bridge: arbitrates the instruction-fetch and data request ports onto
// a single AXI3 master. The data port has priority on the shared read channel.
// Stores go out on AW/W/B. At most one read and one write are in flight.
module axi_req_bridge (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_inst_req,
  input  logic [31:0] io_inst_addr,
  output logic        io_inst_addr_ok,
  output logic        io_inst_data_ok,
  output logic [31:0] io_inst_rdata,

  input  logic        io_data_req,
  input  logic        io_data_wr,
  input  logic [1:0]  io_data_size,
  input  logic [3:0]  io_data_wstrb,
  input  logic [31:0] io_data_addr,
  input  logic [31:0] io_data_wdata,
  output logic        io_data_addr_ok,
  output logic        io_data_data_ok,
  output logic [31:0] io_data_rdata,

  output logic [3:0]  io_axi_ar_id,
  output logic [31:0] io_axi_ar_addr,
  output logic [3:0]  io_axi_ar_len,
  output logic [2:0]  io_axi_ar_size,
  output logic [1:0]  io_axi_ar_burst,
  output logic [1:0]  io_axi_ar_lock,
  output logic [3:0]  io_axi_ar_cache,
  output logic [2:0]  io_axi_ar_prot,
  output logic        io_axi_ar_valid,
  input  logic        io_axi_ar_ready,

  input  logic [3:0]  io_axi_r_id,
  input  logic [31:0] io_axi_r_data,
  input  logic [1:0]  io_axi_r_resp,
  input  logic        io_axi_r_last,
  input  logic        io_axi_r_valid,
  output logic        io_axi_r_ready,

  output logic [3:0]  io_axi_aw_id,
  output logic [31:0] io_axi_aw_addr,
  output logic [3:0]  io_axi_aw_len,
  output logic [2:0]  io_axi_aw_size,
  output logic [1:0]  io_axi_aw_burst,
  output logic [1:0]  io_axi_aw_lock,
  output logic [3:0]  io_axi_aw_cache,
  output logic [2:0]  io_axi_aw_prot,
  output logic        io_axi_aw_valid,
  input  logic        io_axi_aw_ready,

  output logic [3:0]  io_axi_w_id,
  output logic [31:0] io_axi_w_data,
  output logic [3:0]  io_axi_w_strb,
  output logic        io_axi_w_last,
  output logic        io_axi_w_valid,
  input  logic        io_axi_w_ready,

  input  logic [3:0]  io_axi_b_id,
  input  logic [1:0]  io_axi_b_resp,
  input  logic        io_axi_b_valid,
  output logic        io_axi_b_ready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_B} wr_state_t;

  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;

  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic        rd_is_data;

  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_size;
  logic [3:0]  wr_strb;
  logic        aw_done;
  logic        w_done;

  logic        wr_hazard;
  logic        rd_data_accept;
  logic        rd_inst_accept;
  logic        wr_accept;
  logic        r_fire;
  logic        aw_fire;
  logic        w_fire;
  logic        b_fire;

  // Response fields the bridge never looks at: single beats, errors ignored.
  logic        unused_axi_inputs;
  assign unused_axi_inputs = ^{io_axi_r_id, io_axi_r_resp, io_axi_r_last,
                               io_axi_b_id, io_axi_b_resp};

  // A load may not overtake a pending store to the same word.
  assign wr_hazard      = (wr_state != W_IDLE) && (wr_addr[31:2] == io_data_addr[31:2]);
  assign rd_data_accept = !reset && io_data_req && !io_data_wr &&
                          (rd_state == R_IDLE) && !wr_hazard;
  assign rd_inst_accept = !reset && io_inst_req && (rd_state == R_IDLE) && !rd_data_accept;
  assign wr_accept      = !reset && io_data_req && io_data_wr && (wr_state == W_IDLE);

  assign r_fire  = io_axi_r_valid  && io_axi_r_ready;
  assign aw_fire = io_axi_aw_valid && io_axi_aw_ready;
  assign w_fire  = io_axi_w_valid  && io_axi_w_ready;
  assign b_fire  = io_axi_b_valid  && io_axi_b_ready;

  assign io_inst_addr_ok = rd_inst_accept;
  assign io_data_addr_ok = rd_data_accept || wr_accept;
  assign io_inst_data_ok = !reset && r_fire && !rd_is_data;
  assign io_data_data_ok = !reset && ((r_fire && rd_is_data) || b_fire);
  assign io_inst_rdata   = io_axi_r_data;
  assign io_data_rdata   = io_axi_r_data;

  assign io_axi_ar_id    = {3'b000, rd_is_data};
  assign io_axi_ar_addr  = rd_addr;
  assign io_axi_ar_len   = 4'd0;
  assign io_axi_ar_size  = rd_size;
  assign io_axi_ar_burst = 2'b01;
  assign io_axi_ar_lock  = 2'd0;
  assign io_axi_ar_cache = 4'd0;
  assign io_axi_ar_prot  = 3'd0;

  assign io_axi_aw_id    = 4'd1;
  assign io_axi_aw_addr  = wr_addr;
  assign io_axi_aw_len   = 4'd0;
  assign io_axi_aw_size  = wr_size;
  assign io_axi_aw_burst = 2'b01;
  assign io_axi_aw_lock  = 2'd0;
  assign io_axi_aw_cache = 4'd0;
  assign io_axi_aw_prot  = 3'd0;

  assign io_axi_w_id     = 4'd1;
  assign io_axi_w_data   = wr_data;
  assign io_axi_w_strb   = wr_strb;
  assign io_axi_w_last   = 1'b1;

  // Read and write state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // Read next-state and AR/R handshake outputs.
  always_comb begin
    rd_next         = rd_state;
    io_axi_ar_valid = 1'b0;
    io_axi_r_ready  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (rd_data_accept || rd_inst_accept) rd_next = R_AR;
      end
      R_AR: begin
        io_axi_ar_valid = 1'b1;
        if (io_axi_ar_ready) rd_next = R_R;
      end
      R_R: begin
        io_axi_r_ready = 1'b1;
        if (io_axi_r_valid) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Write next-state and AW/W/B handshake outputs; B waits out a data read return.
  always_comb begin
    wr_next         = wr_state;
    io_axi_aw_valid = 1'b0;
    io_axi_w_valid  = 1'b0;
    io_axi_b_ready  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (wr_accept) wr_next = W_ADDR;
      end
      W_ADDR: begin
        io_axi_aw_valid = !aw_done;
        io_axi_w_valid  = !w_done;
        if ((aw_done || aw_fire) && (w_done || w_fire)) wr_next = W_B;
      end
      W_B: begin
        io_axi_b_ready = !(r_fire && rd_is_data);
        if (io_axi_b_valid && io_axi_b_ready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Capture the winning read request's address, size and requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr    <= 32'd0;
      rd_size    <= 3'd0;
      rd_is_data <= 1'b0;
    end else if (rd_data_accept) begin
      rd_addr    <= io_data_addr;
      rd_size    <= {1'b0, io_data_size};
      rd_is_data <= 1'b1;
    end else if (rd_inst_accept) begin
      rd_addr    <= io_inst_addr;
      rd_size    <= 3'd2;
      rd_is_data <= 1'b0;
    end
  end

  // Capture the store payload and track which of AW/W has already handshaken.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr <= 32'd0;
      wr_data <= 32'd0;
      wr_size <= 3'd0;
      wr_strb <= 4'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_accept) begin
      wr_addr <= io_data_addr;
      wr_data <= io_data_wdata;
      wr_size <= {1'b0, io_data_size};
      wr_strb <= io_data_wstrb;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_state == W_ADDR) begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

endmodule
